store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the RV32I core's data-memory port and data memory. It captures every store the core issues as an address, data and write-enable triple. It queues up to DEPTH stores in order and drains them to memory over a valid/ready handshake. It forwards the youngest buffered value to loads that hit a pending address, and stalls the core when full.

## Interface
Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  core store request (core's memory write enable)
- st_addr  in  ADDR_W  store address (core ALU result)
- st_data  in  DATA_W  store data (core write data)
- st_stall  out  1  buffer full; core must hold the store
- ld_addr  in  ADDR_W  load address for forwarding lookup
- ld_hit  out  1  a buffered entry matches ld_addr
- ld_data  out  DATA_W  forwarded data; 0 when ld_hit=0
- mem_valid  out  1  head entry is presented to memory
- mem_addr  out  ADDR_W  head entry address
- mem_data  out  DATA_W  head entry data
- mem_ready  in  1  memory accepts the head entry this cycle
- count  out  $clog2(DEPTH+1)  number of occupied entries
- empty  out  1  count==0

## Operation
- Storage is a circular FIFO of DEPTH entries (addr, data) with head and tail pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.
- Push: occurs when st_valid=1 and st_stall=0. The entry is written at tail, tail increments, count increments.
- st_stall = (count==DEPTH), derived purely from registered count.
  - There is no same-cycle bypass. While full, a store is not accepted even if a pop occurs in that cycle.
  - A store presented while stalled is ignored. The core re-presents it.
- Pop: occurs when mem_valid=1 and mem_ready=1. Head increments and count decrements.
- mem_valid = !empty. mem_addr/mem_data always reflect the head entry. They are stable while mem_valid=1 and mem_ready=0.
- Simultaneous push and pop, only possible when 0<count<DEPTH: count is unchanged, both pointers advance, order is preserved.
- Push into an empty buffer with mem_ready=1 in the same cycle does not pop. The entry first becomes visible at the head on the next cycle.
- Forwarding (combinational):
  - ld_hit=1 when any occupied entry has addr==ld_addr, compared across the full ADDR_W.
  - ld_data is taken from the youngest matching entry, i.e. the one closest to tail.
  - An entry being popped this cycle is still occupied and still forwards.
  - A store being pushed this cycle does not forward until the next cycle.
- No byte enables or merging: each store is one full-width entry. Duplicate addresses occupy separate entries.
- Reset (synchronous): on a rising edge with reset=1, head=tail=count=0 and all pending entries are discarded.
  - This applies mid-drain too. Memory sees mem_valid=0 from the next cycle, and any handshake not completed is abandoned.
  - Entry storage contents need not be cleared.

## Timing
- Reset values, after the first edge with reset=1: count=0, empty=1, mem_valid=0, st_stall=0, ld_hit=0, ld_data=0. mem_addr/mem_data are don't-care while mem_valid=0.
- Store-to-memory latency: a store accepted at edge N reaches an empty buffer's head and asserts mem_valid in the cycle after edge N. With mem_ready=1 it pops at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- st_stall rises in the cycle after the push that fills the buffer. It falls in the cycle after the first pop from full.
- ld_hit/ld_data are combinational from ld_addr and registered state. They are valid within the same cycle.

## Test plan
- Reset: hold reset high for 2 edges with st_valid=1 → count=0, empty=1, mem_valid=0, st_stall=0, nothing pushed.
- Single store: st (addr=100, data=25) with mem_ready=1 → next cycle mem_valid=1, mem_addr=100, mem_data=25. The following cycle empty=1.
- Fill and drain: mem_ready=0, stores to addrs 0,4,8,12 (data 1..4) → count=4, st_stall=1. A fifth store (16,5) is not accepted. Then mem_ready=1 → pops 0,4,8,12 on four consecutive cycles, empty=1 afterwards, addr 16 never appears.
- Forwarding: mem_ready=0, stores (100,25) then (100,26) → ld_addr=100 gives ld_hit=1, ld_data=26. ld_addr=104 gives ld_hit=0, ld_data=0.
- Concurrent push/pop at count=2 with pointer wrap (tail at DEPTH-1) → count stays 2. Drain order matches issue order across the wrap.
- Reset mid-operation: count=3, mem_valid=1, mem_ready=0, assert reset one edge → count=0, mem_valid=0. ld_addr set to a previously buffered address gives ld_hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory: in-order FIFO
// of full-width stores, drained over valid/ready, with youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_stall,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_hit,
    output logic [DATA_W-1:0]            ld_data,
    output logic                         mem_valid,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    input  logic                         mem_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full;
    logic              push;
    logic              pop;

    // Stall comes only from registered occupancy; a pop in the same cycle
    // does not open a slot for the store being presented.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign st_stall  = full;
    assign count     = count_q;

    assign push      = st_valid && !full;
    assign pop       = !empty && mem_ready;

    assign mem_valid = !empty;
    assign mem_addr  = addr_q[head_q];
    assign mem_data  = data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_stall;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic [CW-1:0]     count;
    logic              empty;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    bit   started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pop decided on the pre-edge occupancy, then push appended.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (reset) begin
            q.delete();
            started = 1;
        end else if (started) begin
            do_pop  = (q.size() > 0) && mem_ready;
            do_push = st_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{st_addr, st_data});
        end
    end

    always @(negedge clk) begin
        bit               hit;
        logic [DATA_W-1:0] fd;
        if (started) begin
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_empty", 64'(empty), 64'(q.size() == 0));
            chk("m_mem_valid", 64'(mem_valid), 64'(q.size() != 0));
            chk("m_st_stall", 64'(st_stall), 64'(q.size() == DEPTH));
            if (q.size() != 0) begin
                chk("m_mem_addr", 64'(mem_addr), 64'(q[0].a));
                chk("m_mem_data", 64'(mem_data), 64'(q[0].d));
            end
            hit = 0;
            fd  = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].a == ld_addr) begin
                    hit = 1;
                    fd  = q[i].d;
                end
            end
            chk("m_ld_hit", 64'(ld_hit), 64'(hit));
            chk("m_ld_data", 64'(ld_data), 64'(fd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b1; st_addr = 32'd7; st_data = 32'd9;
        ld_addr = 32'd7; mem_ready = 1'b0;
        step();
        step();
        reset = 1'b0; st_valid = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_st_stall", 64'(st_stall), 64'd0);
        chk("rst_ld_hit", 64'(ld_hit), 64'd0);
        chk("rst_ld_data", 64'(ld_data), 64'd0);

        // Single store with memory ready: head appears next cycle, pops after that.
        mem_ready = 1'b1;
        store(32'd100, 32'd25);
        chk("single_valid", 64'(mem_valid), 64'd1);
        chk("single_addr", 64'(mem_addr), 64'd100);
        chk("single_data", 64'(mem_data), 64'd25);
        step();
        chk("single_empty", 64'(empty), 64'd1);

        // Fill, attempt an overflow store, then drain in order.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(i + 1));
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_stall", 64'(st_stall), 64'd1);
        store(32'd16, 32'd5);
        chk("fill_count_after5", 64'(count), 64'd4);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 64'(mem_valid), 64'd1);
            chk("drain_addr", 64'(mem_addr), 64'(4 * i));
            chk("drain_data", 64'(mem_data), 64'(i + 1));
            step();
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // Forwarding picks the youngest duplicate.
        mem_ready = 1'b0;
        store(32'd100, 32'd25);
        store(32'd100, 32'd26);
        ld_addr = 32'd100;
        #1;
        chk("fwd_hit", 64'(ld_hit), 64'd1);
        chk("fwd_data", 64'(ld_data), 64'd26);
        ld_addr = 32'd104;
        #1;
        chk("fwd_miss_hit", 64'(ld_hit), 64'd0);
        chk("fwd_miss_data", 64'(ld_data), 64'd0);
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        chk("fwd_drained", 64'(empty), 64'd1);

        // Concurrent push/pop at count=2 across the pointer wrap.
        store(32'd200, 32'd1);
        store(32'd204, 32'd2);
        mem_ready = 1'b1;
        store(32'd208, 32'd3);
        chk("cc_count1", 64'(count), 64'd2);
        chk("cc_head1", 64'(mem_addr), 64'd204);
        store(32'd212, 32'd4);
        chk("cc_count2", 64'(count), 64'd2);
        chk("cc_head2", 64'(mem_addr), 64'd208);
        step();
        chk("cc_head3", 64'(mem_addr), 64'd212);
        chk("cc_count3", 64'(count), 64'd1);
        step();
        chk("cc_empty", 64'(empty), 64'd1);

        // Reset mid-operation discards pending entries.
        mem_ready = 1'b0;
        store(32'd400, 32'd40);
        store(32'd404, 32'd41);
        store(32'd408, 32'd42);
        chk("mid_count", 64'(count), 64'd3);
        chk("mid_valid", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ld_addr = 32'd404;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_hit", 64'(ld_hit), 64'd0);

        // Randomized traffic over a small address set to exercise forwarding.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 249) == 0);
            st_valid  = ($urandom_range(0, 99) < 60);
            st_addr   = 32'($urandom_range(0, 7) * 4);
            st_data   = $urandom();
            mem_ready = ($urandom_range(0, 99) < 45);
            ld_addr   = 32'($urandom_range(0, 8) * 4);
            step();
        end
        reset = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
